// File: rtl/uart_loopback_buf.sv
// ---------------------------------------------------------------------------
// uart_loopback_buf
//
// Buffered echo path for the UART driver. Received bytes go into a
// synchronous FIFO. A small FSM then replays them to the transmitter over a
// valid/ready handshake.
//
// Ports
//   i_clk         single clock (driver baud-domain clock)
//   i_rst         asynchronous reset, active low
//   i_rx_data     received byte; qualified by i_rx_valid
//   i_rx_valid    one-cycle strobe from the receiver
//   o_tx_data     byte offered to the transmitter; held while o_tx_valid=1
//   o_tx_valid    offer valid
//   i_tx_ready    transmitter accepts on the edge where valid & ready
//   i_tx_en       1 = draining allowed; 0 = FSM holds in S_IDLE
//   i_clr_ovf     clears the sticky overflow flag (a same-cycle drop wins)
//   o_fifo_count  occupancy, 0..P_FIFO_DEPTH
//   o_full        o_fifo_count == P_FIFO_DEPTH
//   o_empty       o_fifo_count == 0
//   o_overflow    sticky: a byte was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module uart_loopback_buf #(
    parameter int P_DATA_WIDTH = 8,
    parameter int P_FIFO_DEPTH = 16,
    parameter int P_ADDR_WIDTH = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [P_DATA_WIDTH-1:0] i_rx_data,
    input  logic                    i_rx_valid,
    output logic [P_DATA_WIDTH-1:0] o_tx_data,
    output logic                    o_tx_valid,
    input  logic                    i_tx_ready,
    input  logic                    i_tx_en,
    input  logic                    i_clr_ovf,
    output logic [P_ADDR_WIDTH:0]   o_fifo_count,
    output logic                    o_full,
    output logic                    o_empty,
    output logic                    o_overflow
);

    // Pointers are exactly P_ADDR_WIDTH bits wide, so they wrap modulo the
    // depth for free. That only works when the depth is a power of two.
    if (P_FIFO_DEPTH < 2 || P_FIFO_DEPTH != (1 << P_ADDR_WIDTH)) begin : g_bad_param
        $error("uart_loopback_buf: P_FIFO_DEPTH must be 2**P_ADDR_WIDTH and >= 2");
    end

    localparam logic [P_ADDR_WIDTH:0]   LP_CNT_FULL = (P_ADDR_WIDTH+1)'(P_FIFO_DEPTH);
    localparam logic [P_ADDR_WIDTH:0]   LP_CNT_ONE  = (P_ADDR_WIDTH+1)'(1);
    localparam logic [P_ADDR_WIDTH-1:0] LP_PTR_ONE  = P_ADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE,   // wait for data and enable; pop on exit
        S_FETCH,  // RAM read in flight; capture into o_tx_data
        S_VALID,  // offer held until ready
        S_GAP     // one dead cycle so the transmitter can drop ready
    } state_t;

    state_t state, state_nxt;

    logic [P_DATA_WIDTH-1:0] mem [0:P_FIFO_DEPTH-1];
    logic [P_DATA_WIDTH-1:0] rd_data;
    logic [P_ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic                    pop, wr_en, drop;

    assign o_full  = (o_fifo_count == LP_CNT_FULL);
    assign o_empty = (o_fifo_count == '0);

    // A pop frees a slot on the same edge, so a write to a full FIFO is
    // still accepted when it lines up with a pop.
    assign wr_en = i_rx_valid && (!o_full || pop);
    assign drop  = i_rx_valid &&  o_full && !pop;

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                // Transmitter readiness is deliberately not checked here.
                // The offer waits in S_VALID instead.
                if (i_tx_en && !o_empty) begin
                    pop       = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: state_nxt = S_VALID;
            S_VALID: if (i_tx_ready) state_nxt = S_GAP;
            S_GAP:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Offer registers. Valid follows the next state, so it rises on the edge
    // out of S_FETCH and falls on the transfer edge. An offer in progress
    // survives i_tx_en dropping.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_tx_data  <= '0;
            o_tx_valid <= 1'b0;
        end else begin
            if (state == S_FETCH) o_tx_data <= rd_data;
            o_tx_valid <= (state_nxt == S_VALID);
        end
    end

    // ---------------------------------------------------------------------
    // FIFO storage: no reset, registered read
    // ---------------------------------------------------------------------
    // On a full write+pop the two pointers are equal. The nonblocking read
    // returns the old entry, which is the one being popped.
    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_ptr] <= i_rx_data;
        if (pop)   rd_data     <= mem[rd_ptr];
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            o_fifo_count <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + LP_PTR_ONE;
            if (pop)   rd_ptr <= rd_ptr + LP_PTR_ONE;
            case ({wr_en, pop})
                2'b10:   o_fifo_count <= o_fifo_count + LP_CNT_ONE;
                2'b01:   o_fifo_count <= o_fifo_count - LP_CNT_ONE;
                default: o_fifo_count <= o_fifo_count;
            endcase
        end
    end

    // Sticky overflow. A drop on the same edge as a clear takes priority.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)         o_overflow <= 1'b0;
        else if (drop)      o_overflow <= 1'b1;
        else if (i_clr_ovf) o_overflow <= 1'b0;
    end

endmodule

// File: tb/tb_uart_loopback_buf.sv
module tb_uart_loopback_buf;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic [DW-1:0] i_rx_data;
    logic          i_rx_valid;
    logic [DW-1:0] o_tx_data;
    logic          o_tx_valid;
    logic          i_tx_ready;
    logic          i_tx_en;
    logic          i_clr_ovf;
    logic [AW:0]   o_fifo_count;
    logic          o_full;
    logic          o_empty;
    logic          o_overflow;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the ordered list of every byte the FIFO accepted and
    // that has not been transferred yet.
    logic [DW-1:0] exp_q[$];

    uart_loopback_buf #(
        .P_DATA_WIDTH(DW),
        .P_FIFO_DEPTH(DEPTH),
        .P_ADDR_WIDTH(AW)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_rx_data    (i_rx_data),
        .i_rx_valid   (i_rx_valid),
        .o_tx_data    (o_tx_data),
        .o_tx_valid   (o_tx_valid),
        .i_tx_ready   (i_tx_ready),
        .i_tx_en      (i_tx_en),
        .i_clr_ovf    (i_clr_ovf),
        .o_fifo_count (o_fifo_count),
        .o_full       (o_full),
        .o_empty      (o_empty),
        .o_overflow   (o_overflow)
    );

    always #5 i_clk = ~i_clk;

    // Inputs change 1 time unit after a rising edge. Outputs are sampled
    // either there or mid-cycle.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // status = {valid, empty, full, overflow, count}
    task automatic test_reset();
        i_rst = 1'b0; i_rx_data = '0; i_rx_valid = 1'b0; i_tx_ready = 1'b0;
        i_tx_en = 1'b0; i_clr_ovf = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        n_cmp++;
        if ({o_tx_valid, o_empty, o_full, o_overflow, o_fifo_count, o_tx_data} !== {4'b0100, 5'd0, 8'h00}) begin
            n_err++;
            $display("FAIL reset_hold: status=%b%b%b%b cnt=%0d data=%h, need 0100 cnt=0 data=00",
                     o_tx_valid, o_empty, o_full, o_overflow, o_fifo_count, o_tx_data);
        end
        i_rst = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({o_tx_valid, o_empty, o_full, o_overflow, o_fifo_count} !== {4'b0100, 5'd0}) begin
            n_err++;
            $display("FAIL reset_idle: status=%b%b%b%b cnt=%0d, need 0100 cnt=0",
                     o_tx_valid, o_empty, o_full, o_overflow, o_fifo_count);
        end
    endtask

    task automatic test_single();
        int nv;
        i_tx_en = 1'b1; i_tx_ready = 1'b1;
        i_rx_valid = 1'b1; i_rx_data = 8'hA5;
        tick();                       // E0: write
        i_rx_valid = 1'b0;
        n_cmp++;
        if ({o_tx_valid, o_fifo_count} !== {1'b0, 5'd1}) begin
            n_err++;
            $display("FAIL single_e0: valid=%b cnt=%0d, need valid=0 cnt=1", o_tx_valid, o_fifo_count);
        end
        tick();                       // E1: pop
        n_cmp++;
        if ({o_tx_valid, o_fifo_count} !== {1'b0, 5'd0}) begin
            n_err++;
            $display("FAIL single_e1: valid=%b cnt=%0d, need valid=0 cnt=0", o_tx_valid, o_fifo_count);
        end
        tick();                       // E2: offer
        n_cmp++;
        if ({o_tx_valid, o_tx_data} !== {1'b1, 8'hA5}) begin
            n_err++;
            $display("FAIL single_e2: valid=%b data=%h, need valid=1 data=a5", o_tx_valid, o_tx_data);
        end
        nv = 0;
        repeat (6) begin
            tick();
            nv += int'(o_tx_valid);
        end
        n_cmp++;
        if (nv != 0 || o_empty !== 1'b1) begin
            n_err++;
            $display("FAIL single_once: extra valid cycles=%0d empty=%b, need 0 and empty=1", nv, o_empty);
        end
    endtask

    task automatic test_fill();
        i_tx_en = 1'b0; i_tx_ready = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            i_rx_valid = 1'b1; i_rx_data = 8'(i);
            exp_q.push_back(8'(i));
            tick();
        end
        i_rx_valid = 1'b0;
        n_cmp++;
        if ({o_tx_valid, o_empty, o_full, o_overflow, o_fifo_count} !== {4'b0010, 5'd16}) begin
            n_err++;
            $display("FAIL fill_full: status=%b%b%b%b cnt=%0d, need 0010 cnt=16",
                     o_tx_valid, o_empty, o_full, o_overflow, o_fifo_count);
        end
        i_rx_valid = 1'b1; i_rx_data = 8'hFF;   // dropped
        tick();
        i_rx_valid = 1'b0;
        n_cmp++;
        if ({o_overflow, o_fifo_count} !== {1'b1, 5'd16}) begin
            n_err++;
            $display("FAIL fill_drop: ovf=%b cnt=%0d, need ovf=1 cnt=16", o_overflow, o_fifo_count);
        end
        tick();
        n_cmp++;
        if (o_overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_sticky: ovf=%b, need 1", o_overflow);
        end
        i_clr_ovf = 1'b1;
        tick();
        i_clr_ovf = 1'b0;
        n_cmp++;
        if ({o_overflow, o_fifo_count} !== {1'b0, 5'd16}) begin
            n_err++;
            $display("FAIL ovf_clear: ovf=%b cnt=%0d, need ovf=0 cnt=16", o_overflow, o_fifo_count);
        end
    endtask

    task automatic test_drain();
        logic          pv, pr;
        logic [DW-1:0] pd;
        logic [DW-1:0] want;
        bit            done;
        pv = 1'b0; pr = 1'b0; pd = '0; done = 1'b0;
        i_tx_en = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            i_tx_ready = 1'($urandom_range(0, 1));
            #3;
            if (pv && !pr) begin
                n_cmp++;
                if (o_tx_valid !== 1'b1 || o_tx_data !== pd) begin
                    n_err++;
                    $display("FAIL drain_hold: valid=%b data=%h, need valid=1 data=%h", o_tx_valid, o_tx_data, pd);
                end
            end
            if (pv && pr) begin
                n_cmp++;
                if (o_tx_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL drain_gap: valid=%b after transfer, need 0", o_tx_valid);
                end
            end
            if (o_tx_valid && i_tx_ready) begin
                want = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
                n_cmp++;
                if (o_tx_data !== want) begin
                    n_err++;
                    $display("FAIL drain_data: got %h, need %h", o_tx_data, want);
                end
            end
            pv = o_tx_valid; pr = i_tx_ready; pd = o_tx_data;
            if (exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL drain_timeout: %0d bytes still pending, need 0", exp_q.size());
        end
        tick();
        n_cmp++;
        if ({o_tx_valid, o_empty} !== 2'b01) begin
            n_err++;
            $display("FAIL drain_end: valid=%b empty=%b, need valid=0 empty=1", o_tx_valid, o_empty);
        end
    endtask

    // With ready held high a transfer at edge T is followed by GAP at T+1 and
    // the next pop at T+2. Each new byte is strobed onto that pop edge.
    task automatic test_stream();
        int            sent, wr_cd, ncnt, novf, nbad;
        logic [DW-1:0] want, b;
        bit            done;
        sent = 0; wr_cd = 0; ncnt = 0; novf = 0; nbad = 0; done = 1'b0;
        i_tx_en = 1'b1; i_tx_ready = 1'b1;
        repeat (3) begin
            b = 8'($urandom);
            i_rx_valid = 1'b1; i_rx_data = b;
            exp_q.push_back(b);
            sent++;
            tick();
        end
        i_rx_valid = 1'b0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            i_rx_valid = 1'b0;
            if (wr_cd > 0) begin
                wr_cd--;
                if (wr_cd == 0 && sent < 40) begin
                    b = 8'($urandom);
                    i_rx_valid = 1'b1; i_rx_data = b;
                    exp_q.push_back(b);
                    sent++;
                end
            end
            #3;
            if (o_fifo_count > 5'(DEPTH)) ncnt++;
            if (o_overflow !== 1'b0) novf++;
            if (o_tx_valid && i_tx_ready) begin
                want = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
                n_cmp++;
                if (o_tx_data !== want) begin
                    n_err++; nbad++;
                    $display("FAIL stream_data: got %h, need %h", o_tx_data, want);
                end
                wr_cd = 2;
            end
            if (sent == 40 && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        i_rx_valid = 1'b0;
        n_cmp++;
        if (!done || ncnt != 0 || novf != 0) begin
            n_err++;
            $display("FAIL stream_end: done=%b sent=%0d pending=%0d cnt>16 cycles=%0d ovf cycles=%0d, need done sent=40 0 0 0",
                     done, sent, exp_q.size(), ncnt, novf);
        end
        tick();
    endtask

    task automatic test_full_simul();
        logic [DW-1:0] b, want;
        bit            done;
        done = 1'b0;
        i_tx_en = 1'b0; i_tx_ready = 1'b0;
        repeat (3) tick();
        repeat (DEPTH) begin
            b = 8'($urandom);
            i_rx_valid = 1'b1; i_rx_data = b;
            exp_q.push_back(b);
            tick();
        end
        i_rx_valid = 1'b0;
        n_cmp++;
        if ({o_full, o_fifo_count} !== {1'b1, 5'd16}) begin
            n_err++;
            $display("FAIL simul_pre: full=%b cnt=%0d, need full=1 cnt=16", o_full, o_fifo_count);
        end
        b = 8'($urandom);
        i_tx_en = 1'b1; i_rx_valid = 1'b1; i_rx_data = b;
        exp_q.push_back(b);
        tick();                       // pop and write on the same edge
        i_rx_valid = 1'b0;
        n_cmp++;
        if ({o_full, o_overflow, o_fifo_count} !== {2'b10, 5'd16}) begin
            n_err++;
            $display("FAIL simul_edge: full=%b ovf=%b cnt=%0d, need full=1 ovf=0 cnt=16",
                     o_full, o_overflow, o_fifo_count);
        end
        i_tx_ready = 1'b1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            #3;
            if (o_tx_valid && i_tx_ready) begin
                want = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
                n_cmp++;
                if (o_tx_data !== want) begin
                    n_err++;
                    $display("FAIL simul_data: got %h, need %h", o_tx_data, want);
                end
            end
            if (exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        tick();
        n_cmp++;
        if (!done || o_empty !== 1'b1 || o_overflow !== 1'b0) begin
            n_err++;
            $display("FAIL simul_end: done=%b empty=%b ovf=%b pending=%0d, need 1 1 0 0",
                     done, o_empty, o_overflow, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        int nv;
        seen = 1'b0;
        i_tx_en = 1'b1; i_tx_ready = 1'b0;
        i_rx_valid = 1'b1; i_rx_data = 8'($urandom);
        tick();
        i_rx_valid = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            tick();
            if (o_tx_valid) begin
                seen = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL rstmid_offer: valid never rose within 10 cycles, need 1");
        end
        #3;                           // mid-cycle, no clock edge involved
        i_rst = 1'b0;
        #1;
        n_cmp++;
        if ({o_tx_valid, o_empty, o_fifo_count, o_tx_data} !== {2'b01, 5'd0, 8'h00}) begin
            n_err++;
            $display("FAIL rstmid_async: valid=%b empty=%b cnt=%0d data=%h, need 0 1 0 00",
                     o_tx_valid, o_empty, o_fifo_count, o_tx_data);
        end
        exp_q.delete();
        tick();
        i_rst = 1'b1; i_tx_ready = 1'b1;
        nv = 0;
        repeat (6) begin
            tick();
            nv += int'(o_tx_valid);
        end
        n_cmp++;
        if (nv != 0) begin
            n_err++;
            $display("FAIL rstmid_lost: valid cycles after reset=%0d, need 0", nv);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_drain();
        test_stream();
        test_full_simul();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, need completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_loopback_buf.md
Name: uart_loopback_buf

Overview:
- User-side counterpart of the UART driver's user interface.
- Consumes received bytes (single-cycle valid strobe from the receiver) into a synchronous FIFO.
- Replays the buffered bytes to the transmitter over its valid/ready handshake.
- Sits between the driver's rx outputs and tx inputs to form a buffered echo path, and reports FIFO occupancy and overflow.

Parameters:
- P_DATA_WIDTH, 8, byte width; matches the driver's data width.
- P_FIFO_DEPTH, 16, FIFO entries; must be a power of two and at least 2.
- P_ADDR_WIDTH, 4, log2(P_FIFO_DEPTH).

Ports:
- i_clk  input  1  single clock (the driver's baud-domain clock).
- i_rst  input  1  asynchronous, active-low reset.
- i_rx_data  input  P_DATA_WIDTH  received byte.
- i_rx_valid  input  1  one-cycle strobe; i_rx_data is valid in the same cycle.
- o_tx_data  output  P_DATA_WIDTH  byte offered to the transmitter.
- o_tx_valid  output  1  offer valid.
- i_tx_ready  input  1  transmitter can accept.
- i_tx_en  input  1  1 = draining allowed; 0 = hold in IDLE.
- i_clr_ovf  input  1  clears the sticky overflow flag.
- o_fifo_count  output  P_ADDR_WIDTH+1  current occupancy, 0..P_FIFO_DEPTH.
- o_full  output  1  o_fifo_count == P_FIFO_DEPTH.
- o_empty  output  1  o_fifo_count == 0.
- o_overflow  output  1  sticky: a byte was dropped because the FIFO was full.

Behaviour:
- Reset (i_rst=0, asynchronous): pointers and count = 0; o_tx_data = 0; o_tx_valid = 0; o_overflow = 0; FSM = S_IDLE. o_empty = 1 and o_full = 0 during reset. RAM contents need no reset.
- o_full and o_empty are combinational from the count register.
- Write: at the edge where i_rx_valid=1 and the FIFO is not full, store the byte at wr_ptr and increment wr_ptr (wraps modulo depth).
- Write when full: at that edge the byte is dropped, no pointer or count change, and o_overflow is set.
- i_clr_ovf=1 clears o_overflow. If a drop occurs in the same cycle as i_clr_ovf, set wins.
- Read: registered RAM read, 1-cycle latency. A pop increments rd_ptr (wraps modulo depth).
- Count: +1 on write only, −1 on pop only, unchanged on a simultaneous write and pop. A write is accepted when full only if a pop occurs on the same edge; in that case count stays at P_FIFO_DEPTH and no overflow is flagged.
- S_IDLE: if i_tx_en=1 and the FIFO is not empty, pop (issue read) -> S_FETCH. Otherwise stay. Readiness of the transmitter is not checked here.
- S_FETCH: load RAM output into o_tx_data, set o_tx_valid=1 -> S_VALID.
- S_VALID: hold o_tx_data stable and o_tx_valid=1 until the edge where i_tx_ready=1 (transfer). At that edge clear o_tx_valid -> S_GAP. i_tx_en=0 does not withdraw an offer already in progress.
- S_GAP: one cycle with o_tx_valid=0 so the transmitter can drop ready -> S_IDLE.
- Latency: write edge E0 -> pop at E1 -> o_tx_valid=1 after E2. Minimum spacing between offers is 4 cycles (IDLE, FETCH, VALID, GAP).
- o_tx_valid never rises while the FIFO was empty at the IDLE decision.
- Data ordering is strict FIFO. Pointer wrap must be exercised and must not corrupt data.
- Reset mid-offer: o_tx_valid drops immediately (asynchronous), the FIFO empties, and the byte in flight is lost.

Test Plan:
- Reset then idle -> o_tx_valid=0, o_empty=1, o_fifo_count=0, o_overflow=0. Assert reset mid-S_VALID -> o_tx_valid falls with no clock edge.
- Single byte 0xA5 strobed, i_tx_ready=1 held -> o_tx_valid high exactly 2 edges after the write edge with o_tx_data=0xA5; one transfer; o_empty=1 afterwards.
- Write 0x01..0x10 (16 bytes) with i_tx_en=0 -> o_full=1, count=16. 17th byte 0xFF -> dropped, o_overflow=1, count stays 16. Pulse i_clr_ovf -> o_overflow=0.
- From full, set i_tx_en=1 and toggle i_tx_ready randomly -> output sequence is exactly 0x01..0x10. o_tx_data stays stable while valid=1 and ready=0, and valid drops for at least 1 cycle between bytes.
- Streaming 40 bytes with writes coinciding with pops (pointer wrap twice) -> every byte echoed in order, count never exceeds 16, no overflow.
- Full FIFO with a write strobe on the same edge as a pop -> byte accepted, count stays 16, o_overflow remains 0.
